// File: rtl/aes_diff_pkg.sv
// rtl/aes_diff_pkg.sv - shared types and GF(2^8)/row-shift helpers for the AES diffusion layer
// Contents: state_t (row x column byte array), diff_state_e (FSM states),
//           xtime/gmul (GF(2^8) over 0x11B), shift_rows/inv_shift_rows,
//           pack/unpack between 128-bit vectors (byte k = v[127-8k -: 8]) and state_t.
// Option: AES_DIFF_INV_EN adds the ISHIFT state used by the inverse datapath.
package aes_diff_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    // s[r][c] holds byte r+4c of the 128-bit vector
    typedef logic [3:0][3:0][7:0] state_t;

`ifdef AES_DIFF_INV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MIX, ST_ISHIFT, ST_DONE} diff_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_MIX, ST_DONE} diff_state_e;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiplier constants never exceed 0x0e, so four partial products suffice
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic state_t unpack(input logic [127:0] v);
        state_t s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = v[127 - 8 * (4 * c + r) -: 8];
        return s;
    endfunction

    function automatic logic [127:0] pack(input state_t s);
        logic [127:0] v;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v[127 - 8 * (4 * c + r) -: 8] = s[r][c];
        return v;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = s[r][(c + r) % 4];
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][(c + r) % 4] = s[r][c];
        return o;
    endfunction

endpackage

// File: rtl/aes_mixcol_unit.sv
// rtl/aes_mixcol_unit.sv - combinational MixColumns / InvMixColumns of one 32-bit column
// Ports: col   - input column, row 0 in col[31:24]
//        inv   - 1 selects InvMixColumns (honoured only with AES_DIFF_INV_EN)
//        mixed - mixed column, same byte order as col
// Option: AES_DIFF_INV_EN; when undefined the inverse matrix is not built and inv is unused.
module aes_mixcol_unit
    import aes_diff_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] mixed
);

    logic [7:0] a   [4];
    logic [7:0] fwd [4];

    always_comb begin
        for (int i = 0; i < 4; i++) a[i] = col[31 - 8 * i -: 8];
        for (int i = 0; i < 4; i++)
            fwd[i] = gmul(a[i], 4'h2) ^ gmul(a[(i + 1) % 4], 4'h3)
                   ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
    end

`ifdef AES_DIFF_INV_EN
    logic [7:0] bwd [4];

    always_comb begin
        for (int i = 0; i < 4; i++)
            bwd[i] = gmul(a[i], 4'he) ^ gmul(a[(i + 1) % 4], 4'hb)
                   ^ gmul(a[(i + 2) % 4], 4'hd) ^ gmul(a[(i + 3) % 4], 4'h9);
        mixed = inv ? {bwd[0], bwd[1], bwd[2], bwd[3]}
                    : {fwd[0], fwd[1], fwd[2], fwd[3]};
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign mixed = {fwd[0], fwd[1], fwd[2], fwd[3]};
`endif

endmodule

// File: rtl/aes_diffusion_seq.sv
// rtl/aes_diffusion_seq.sv - sequential handshaked AES ShiftRows+MixColumns (and inverse) layer
// Ports: clk, rst_n (sync, active-low);
//        in_valid/in_ready/in_state/mode_inv/skip_mix - input handshake, sampled on acceptance;
//        out_valid/out_ready/out_state - result handshake; busy - high outside IDLE.
// Parameter: COLS_PER_CYCLE (1, 2 or 4) columns mixed per clock.
// Option: AES_DIFF_INV_EN enables the inverse datapath and the ISHIFT state.
module aes_diffusion_seq
    import aes_diff_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         mode_inv,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] COL_STEP   = 2'(COLS_PER_CYCLE);
    // col_cnt value of the group that contains column 3
    localparam logic [1:0] LAST_GROUP = 2'(4 - COLS_PER_CYCLE);

    diff_state_e      state;
    logic [1:0]       col_cnt;
    // Column c lives in work[3-c] because byte 0 sits at the MSB end
    logic [3:0][31:0] work;
    logic [3:0][31:0] mixed_work;
    logic             cur_inv;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] mix_in  [COLS_PER_CYCLE];
    logic [31:0] mix_out [COLS_PER_CYCLE];

`ifdef AES_DIFF_INV_EN
    logic inv_q;
    assign cur_inv = inv_q;
`else
    logic unused_mode_inv;
    assign unused_mode_inv = mode_inv;
    assign cur_inv = 1'b0;
`endif

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        assign col_idx[g] = col_cnt + 2'(g);
        assign mix_in[g]  = work[~col_idx[g]];
        aes_mixcol_unit u_mix (
            .col   (mix_in[g]),
            .inv   (cur_inv),
            .mixed (mix_out[g])
        );
    end

    always_comb begin
        mixed_work = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++)
            mixed_work[~col_idx[g]] = mix_out[g];
    end

    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_state = work;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            col_cnt  <= 2'd0;
            work     <= '0;
            in_ready <= 1'b0;
`ifdef AES_DIFF_INV_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        col_cnt  <= 2'd0;
`ifdef AES_DIFF_INV_EN
                        inv_q <= mode_inv;
                        work  <= mode_inv ? in_state : pack(shift_rows(unpack(in_state)));
                        state <= skip_mix ? (mode_inv ? ST_ISHIFT : ST_DONE) : ST_MIX;
`else
                        work  <= pack(shift_rows(unpack(in_state)));
                        state <= skip_mix ? ST_DONE : ST_MIX;
`endif
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_MIX: begin
                    work    <= mixed_work;
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_cnt == LAST_GROUP) begin
`ifdef AES_DIFF_INV_EN
                        state <= inv_q ? ST_ISHIFT : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef AES_DIFF_INV_EN
                ST_ISHIFT: begin
                    work  <= pack(inv_shift_rows(unpack(work)));
                    state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_diffusion_seq.sv
// tb/tb_aes_diffusion_seq.sv - directed and swept checks of aes_diffusion_seq at 1, 2 and 4 columns per cycle
module tb_aes_diffusion_seq;

    localparam logic [127:0] V_PLAIN = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] V_MIXED = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V_SEQ   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] V_SEQSR = 128'h00050a0f_04090e03_080d0207_0c01060b;
    localparam logic [127:0] V_DB    = 128'hdb000000_00130000_00005300_00000045;
    localparam logic [127:0] V_DBMIX = 128'h8e4da1bc_00000000_00000000_00000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         mode_inv;
    logic         skip_mix;
    logic         out_ready;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   bz;
    logic [127:0] out_st [3];

    int           checks   = 0;
    int           failures = 0;
    int           lat [3];
    logic [127:0] res [3];

    always #5 clk = ~clk;

    aes_diffusion_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
        .mode_inv(mode_inv), .skip_mix(skip_mix), .out_valid(ov[0]), .out_ready(out_ready),
        .out_state(out_st[0]), .busy(bz[0]));
    aes_diffusion_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
        .mode_inv(mode_inv), .skip_mix(skip_mix), .out_valid(ov[1]), .out_ready(out_ready),
        .out_state(out_st[1]), .busy(bz[1]));
    aes_diffusion_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
        .mode_inv(mode_inv), .skip_mix(skip_mix), .out_valid(ov[2]), .out_ready(out_ready),
        .out_state(out_st[2]), .busy(bz[2]));

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef AES_DIFF_INV_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [127:0] ref_diff(input logic [127:0] s, input logic inv, input logic skip);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [7:0] x2, x4, x8;
        logic [7:0] t9 [4], tb [4], td [4], te [4];
        logic [127:0] v;
        for (int k = 0; k < 16; k++) b[k] = s[127 - 8 * k -: 8];
        if (!inv)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    o[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
                end
        else
            for (int k = 0; k < 16; k++) o[k] = b[k];
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) b[r] = o[r + 4 * c];
                for (int r = 0; r < 4; r++) begin
                    x2 = xt(b[r]); x4 = xt(x2); x8 = xt(x4);
                    t9[r] = x8 ^ b[r]; tb[r] = x8 ^ x2 ^ b[r];
                    td[r] = x8 ^ x4 ^ b[r]; te[r] = x8 ^ x4 ^ x2;
                end
                for (int r = 0; r < 4; r++)
                    if (!inv)
                        o[r + 4 * c] = xt(b[r]) ^ xt(b[(r + 1) % 4]) ^ b[(r + 1) % 4]
                                     ^ b[(r + 2) % 4] ^ b[(r + 3) % 4];
                    else
                        o[r + 4 * c] = te[r] ^ tb[(r + 1) % 4] ^ td[(r + 2) % 4] ^ t9[(r + 3) % 4];
            end
        end
        if (inv) begin
            for (int k = 0; k < 16; k++) b[k] = o[k];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) o[r + 4 * ((c + r) % 4)] = b[r + 4 * c];
        end
        for (int k = 0; k < 16; k++) v[127 - 8 * k -: 8] = o[k];
        return v;
    endfunction

    function automatic int exp_lat(input int idx, input logic inv, input logic skip);
        int n;
        n = 4 >> idx;
        if (skip) return inv ? 1 : 0;
        return inv ? n + 1 : n;
    endfunction

    // Drives one transaction into all three DUTs and records result and latency of each
    task automatic run_txn(input logic [127:0] st, input logic inv, input logic skip);
        int waited;
        waited = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin lat[i] = -1; res[i] = '0; end
        while (ir != 3'b111 && waited < 20) begin @(negedge clk); waited++; end
        if (ir != 3'b111) return;
        in_state = st; mode_inv = inv; skip_mix = skip; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        for (int e = 0; e < 12; e++) begin
            for (int i = 0; i < 3; i++)
                if (lat[i] < 0 && ov[i]) begin lat[i] = e; res[i] = out_st[i]; end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; mode_inv = 1'b0; skip_mix = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ir[i], ov[i], bz[i]} !== 3'b000) begin
                failures++; $display("FAIL reset_flags dut%0d ir/ov/busy=%b expected 000", i, {ir[i], ov[i], bz[i]});
            end
            checks++;
            if (out_st[i] !== 128'h0) begin
                failures++; $display("FAIL reset_state dut%0d got %h expected 0", i, out_st[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ir !== 3'b111) begin failures++; $display("FAIL reset_release in_ready=%b expected 111", ir); end
    endtask

    task automatic test_known_vectors();
        run_txn(V_PLAIN, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res[i] !== V_MIXED) begin failures++; $display("FAIL fwd_vec dut%0d got %h expected %h", i, res[i], V_MIXED); end
            checks++;
            if (lat[i] !== (4 >> i)) begin failures++; $display("FAIL fwd_lat dut%0d got %0d expected %0d", i, lat[i], 4 >> i); end
        end
        run_txn(V_SEQ, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res[i] !== V_SEQSR) begin failures++; $display("FAIL skip_vec dut%0d got %h expected %h", i, res[i], V_SEQSR); end
            checks++;
            if (lat[i] !== 0) begin failures++; $display("FAIL skip_lat dut%0d got %0d expected 0", i, lat[i]); end
        end
        run_txn(V_DB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res[i] !== V_DBMIX) begin failures++; $display("FAIL db_col dut%0d got %h expected %h", i, res[i], V_DBMIX); end
        end
`ifdef AES_DIFF_INV_EN
        run_txn(V_MIXED, 1'b1, 1'b0);
        checks++;
        if (res[0] !== V_PLAIN) begin failures++; $display("FAIL inv_vec got %h expected %h", res[0], V_PLAIN); end
        checks++;
        if (lat[0] !== 5) begin failures++; $display("FAIL inv_lat got %0d expected 5", lat[0]); end
`endif
    endtask

    task automatic test_backpressure();
        int waited;
        out_ready = 1'b0;
        in_state = V_PLAIN; mode_inv = 1'b0; skip_mix = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (ov != 3'b111 && waited < 12) begin @(posedge clk); @(negedge clk); waited++; end
        checks++;
        if (ov !== 3'b111) begin failures++; $display("FAIL bp_reach_done out_valid=%b expected 111", ov); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = cyc[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_st[i] !== V_MIXED || ov[i] !== 1'b1 || ir[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_hold dut%0d cyc%0d state=%h ov=%b ir=%b expected %h 1 0",
                             i, cyc, out_st[i], ov[i], ir[i], V_MIXED);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov !== 3'b000 || ir !== 3'b111 || bz !== 3'b000) begin
            failures++; $display("FAIL bp_release ov=%b ir=%b busy=%b expected 000 111 000", ov, ir, bz);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_state = V_SEQ; mode_inv = 1'b0; skip_mix = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
            failures++; $display("FAIL mid_busy dut0 busy=%b ov=%b expected 1 0", bz[0], ov[0]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov !== 3'b000 || bz !== 3'b000 || ir !== 3'b000) begin
            failures++; $display("FAIL mid_reset ov=%b busy=%b ir=%b expected 000 000 000", ov, bz, ir);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ir !== 3'b111 || ov !== 3'b000) begin
            failures++; $display("FAIL mid_release ir=%b ov=%b expected 111 000", ir, ov);
        end
        run_txn(V_PLAIN, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res[i] !== V_MIXED || lat[i] !== (4 >> i)) begin
                failures++; $display("FAIL mid_next dut%0d got %h lat %0d expected %h lat %0d",
                                     i, res[i], lat[i], V_MIXED, 4 >> i);
            end
        end
    endtask

    task automatic test_sweep();
        logic [127:0] st;
        logic [127:0] exp_st;
        logic         inv;
        logic         skip;
        for (int combo = 0; combo < 4; combo++) begin
            inv  = combo[0];
            skip = combo[1];
            for (int t = 0; t < 50; t++) begin
                st = {$urandom, $urandom, $urandom, $urandom};
                exp_st = ref_diff(st, eff_inv(inv), skip);
                run_txn(st, inv, skip);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (res[i] !== exp_st) begin
                        failures++; $display("FAIL sweep_data dut%0d inv%0d skip%0d got %h expected %h",
                                             i, inv, skip, res[i], exp_st);
                    end
                    checks++;
                    if (lat[i] !== exp_lat(i, eff_inv(inv), skip)) begin
                        failures++; $display("FAIL sweep_lat dut%0d inv%0d skip%0d got %0d expected %0d",
                                             i, inv, skip, lat[i], exp_lat(i, eff_inv(inv), skip));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
